// File: rtl/sprite_draw_scheduler.sv
// Per-frame sprite draw sequencer: buffers host draw commands and replays a committed
// batch (optional clear, then draws in order) against graphics_accelerator on the next frame tick.
module sprite_draw_scheduler #(
  parameter int DEPTH    = 16,
  parameter int TIMEOUT  = 4000000,
  parameter int CLEAR_EN = 1
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [3:0]               cmd_sheetX,
  input  logic [2:0]               cmd_sheetY,
  input  logic [9:0]               cmd_imgX,
  input  logic [9:0]               cmd_imgY,
  input  logic                     commit,
  input  logic                     frame_clk,
  input  logic                     gfx_done,
  output logic [3:0]               spritesheetX,
  output logic [2:0]               spritesheetY,
  output logic [9:0]               imgX,
  output logic [9:0]               imgY,
  output logic                     draw_start,
  output logic                     clear_start,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     batch_done,
  output logic                     timeout_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_FRAME, CLR, CLR_REL, NEXT, DRAW, DRAW_REL, FIN
  } state_t;

  state_t          state_q;
  logic [26:0]     mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d, batch_q, pop_n;
  logic [TW-1:0]   wcnt_q;
  logic            frame_q, pending_q;
  logic            clear_start_q, draw_start_q, batch_done_q, timeout_err_q;
  logic [3:0]      sheet_x_q;
  logic [2:0]      sheet_y_q;
  logic [9:0]      img_x_q, img_y_q;
  logic            push, fe, waiting, progress, abort;

  always_comb begin
    cmd_ready = (count_q != CW'(DEPTH));
    push      = cmd_valid & cmd_ready;
    fe        = frame_clk & ~frame_q;
    waiting   = (state_q == CLR) || (state_q == CLR_REL) ||
                (state_q == DRAW) || (state_q == DRAW_REL);
    progress  = (((state_q == CLR) || (state_q == DRAW)) && gfx_done) ||
                (((state_q == CLR_REL) || (state_q == DRAW_REL)) && !gfx_done);
    abort     = waiting && !progress && (wcnt_q == TW'(TIMEOUT - 1));
    // An abort discards every entry still owed to the current batch in one step.
    pop_n     = '0;
    if (abort)
      pop_n = batch_q;
    else if ((state_q == NEXT) && (batch_q != '0))
      pop_n = CW'(1);
    count_d   = count_q + CW'(push) - pop_n;
    rd_ptr_d  = rd_ptr_q + pop_n[AW-1:0];
  end

  always_ff @(posedge Clk) begin
    if (push)
      mem_q[wr_ptr_q] <= {cmd_sheetX, cmd_sheetY, cmd_imgX, cmd_imgY};
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      batch_q       <= '0;
      wcnt_q        <= '0;
      frame_q       <= 1'b0;
      pending_q     <= 1'b0;
      clear_start_q <= 1'b0;
      draw_start_q  <= 1'b0;
      batch_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      sheet_x_q     <= '0;
      sheet_y_q     <= '0;
      img_x_q       <= '0;
      img_y_q       <= '0;
    end else begin
      frame_q      <= frame_clk;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      batch_done_q <= 1'b0;
      if (push)
        wr_ptr_q <= wr_ptr_q + AW'(1);
      if (commit)
        pending_q <= 1'b1;
      if (waiting)
        wcnt_q <= wcnt_q + TW'(1);
      if (abort) begin
        clear_start_q <= 1'b0;
        draw_start_q  <= 1'b0;
        timeout_err_q <= 1'b1;
        batch_q       <= '0;
        batch_done_q  <= 1'b1;
        state_q       <= FIN;
      end else begin
        case (state_q)
          IDLE: if (pending_q) begin
            pending_q <= 1'b0;
            batch_q   <= count_q;
            state_q   <= WAIT_FRAME;
          end
          WAIT_FRAME: if (fe) begin
            wcnt_q  <= '0;
            state_q <= (CLEAR_EN != 0) ? CLR : NEXT;
          end
          CLR: if (gfx_done) begin
            clear_start_q <= 1'b0;
            wcnt_q        <= '0;
            state_q       <= CLR_REL;
          end else begin
            clear_start_q <= 1'b1;
          end
          CLR_REL: if (!gfx_done) state_q <= NEXT;
          NEXT: if (batch_q == '0) begin
            batch_done_q <= 1'b1;
            state_q      <= FIN;
          end else begin
            {sheet_x_q, sheet_y_q, img_x_q, img_y_q} <= mem_q[rd_ptr_q];
            batch_q <= batch_q - CW'(1);
            wcnt_q  <= '0;
            state_q <= DRAW;
          end
          DRAW: if (gfx_done) begin
            draw_start_q <= 1'b0;
            wcnt_q       <= '0;
            state_q      <= DRAW_REL;
          end else begin
            draw_start_q <= 1'b1;
          end
          DRAW_REL: if (!gfx_done) state_q <= NEXT;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign spritesheetX = sheet_x_q;
  assign spritesheetY = sheet_y_q;
  assign imgX         = img_x_q;
  assign imgY         = img_y_q;
  assign draw_start   = draw_start_q;
  assign clear_start  = clear_start_q;
  assign busy         = (state_q != IDLE);
  assign fifo_count   = count_q;
  assign batch_done   = batch_done_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Directed bench for sprite_draw_scheduler with a small accelerator responder model.
module tb_sprite_draw_scheduler;

  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 100;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_sheetX = '0;
  logic [2:0] cmd_sheetY = '0;
  logic [9:0] cmd_imgX = '0;
  logic [9:0] cmd_imgY = '0;
  logic       commit = 1'b0;
  logic       frame_clk = 1'b0;
  logic       gfx_done = 1'b0;
  logic [3:0] spritesheetX;
  logic [2:0] spritesheetY;
  logic [9:0] imgX, imgY;
  logic       draw_start, clear_start, busy, batch_done, timeout_err;
  logic [4:0] fifo_count;

  always #5 Clk = ~Clk;

  sprite_draw_scheduler #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CLEAR_EN(1)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_sheetX(cmd_sheetX), .cmd_sheetY(cmd_sheetY),
    .cmd_imgX(cmd_imgX), .cmd_imgY(cmd_imgY),
    .commit(commit), .frame_clk(frame_clk), .gfx_done(gfx_done),
    .spritesheetX(spritesheetX), .spritesheetY(spritesheetY),
    .imgX(imgX), .imgY(imgY),
    .draw_start(draw_start), .clear_start(clear_start),
    .busy(busy), .fifo_count(fifo_count),
    .batch_done(batch_done), .timeout_err(timeout_err)
  );

  // Accelerator: raises done five cycles into a start, drops it once start falls.
  logic stuck = 1'b0;
  int   acc_cnt = 0;
  always @(negedge Clk) begin
    if (stuck || !(clear_start || draw_start)) begin
      acc_cnt  = 0;
      gfx_done = 1'b0;
    end else begin
      acc_cnt++;
      if (acc_cnt >= 5) gfx_done = 1'b1;
    end
  end

  int         clr_rise = 0, drw_rise = 0, bd_cnt = 0, clr_high = 0, overlap = 0;
  logic [9:0] xlog[$];
  logic       pc = 1'b0, pd = 1'b0;
  always @(negedge Clk) begin
    if (clear_start && !pc) clr_rise++;
    if (draw_start && !pd) begin
      drw_rise++;
      xlog.push_back(imgX);
    end
    if (clear_start) clr_high++;
    if (clear_start && draw_start) overlap++;
    if (batch_done) bd_cnt++;
    pc = clear_start;
    pd = draw_start;
  end

  int checks = 0, failures = 0;
  int b_clr, b_drw, b_bd, b_high, b_x;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic snap();
    b_clr  = clr_rise;
    b_drw  = drw_rise;
    b_bd   = bd_cnt;
    b_high = clr_high;
    b_x    = xlog.size();
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    repeat (3) tick();
    Reset_n = 1'b1;
    tick();
  endtask

  task automatic push(input logic [9:0] x, input logic [9:0] y,
                      input logic [3:0] sx, input logic [2:0] sy);
    cmd_imgX = x; cmd_imgY = y; cmd_sheetX = sx; cmd_sheetY = sy;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic pulse_commit();
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  task automatic pulse_frame();
    frame_clk = 1'b1;
    tick();
    frame_clk = 1'b0;
  endtask

  task automatic wait_bd(input int target, input string tag);
    for (int i = 0; i < 2000 && bd_cnt < target; i++) tick();
    check_eq(tag, bd_cnt, target);
    tick();
  endtask

  task automatic wait_draw(input string tag);
    for (int i = 0; i < 500 && !draw_start; i++) tick();
    check_eq(tag, draw_start, 1);
  endtask

  initial begin
    int n;
    logic seen_low;

    do_reset();
    check_eq("rst_cmd_ready", cmd_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_fifo", fifo_count, 0);
    check_eq("rst_draw", draw_start, 0);
    check_eq("rst_clear", clear_start, 0);
    check_eq("rst_bd", batch_done, 0);
    check_eq("rst_terr", timeout_err, 0);
    check_eq("rst_imgx", imgX, 0);

    // Three commands drawn in order after one clear
    snap();
    push(10'd10, 10'd1, 4'd1, 3'd1);
    push(10'd20, 10'd2, 4'd2, 3'd2);
    push(10'd30, 10'd3, 4'd3, 3'd3);
    check_eq("t2_fifo3", fifo_count, 3);
    pulse_commit();
    repeat (3) tick();
    check_eq("t2_wait_busy", busy, 1);
    check_eq("t2_wait_noclr", clear_start, 0);
    pulse_frame();
    wait_bd(b_bd + 1, "t2_bd_wait");
    check_eq("t2_clears", clr_rise - b_clr, 1);
    check_eq("t2_draws", drw_rise - b_drw, 3);
    check_eq("t2_x0", xlog[b_x], 10);
    check_eq("t2_x1", xlog[b_x + 1], 20);
    check_eq("t2_x2", xlog[b_x + 2], 30);
    check_eq("t2_bd_once", bd_cnt - b_bd, 1);
    check_eq("t2_fifo0", fifo_count, 0);
    check_eq("t2_idle", busy, 0);
    check_eq("t2_sheetx", spritesheetX, 3);
    check_eq("t2_imgy", imgY, 3);

    // Push after commit belongs to the next batch
    snap();
    push(10'd40, 10'd4, 4'd4, 3'd4);
    push(10'd50, 10'd5, 4'd5, 3'd5);
    pulse_commit();
    repeat (3) tick();
    push(10'd60, 10'd6, 4'd6, 3'd6);
    pulse_frame();
    wait_bd(b_bd + 1, "t3_bd_wait");
    check_eq("t3_draws", drw_rise - b_drw, 2);
    check_eq("t3_x0", xlog[b_x], 40);
    check_eq("t3_x1", xlog[b_x + 1], 50);
    check_eq("t3_fifo1", fifo_count, 1);

    // Reset held mid-draw
    pulse_commit();
    repeat (3) tick();
    pulse_frame();
    wait_draw("t1_draw_seen");
    Reset_n = 1'b0;
    tick();
    check_eq("t1_draw_drop", draw_start, 0);
    repeat (2) tick();
    check_eq("t1_fifo", fifo_count, 0);
    check_eq("t1_busy", busy, 0);
    check_eq("t1_cmd_ready", cmd_ready, 1);
    Reset_n = 1'b1;
    tick();

    // Fill to DEPTH, then an ignored extra push
    for (int i = 0; i < DEPTH; i++) push(10'(i), 10'd0, 4'd0, 3'd0);
    check_eq("t4_full_cnt", fifo_count, 16);
    check_eq("t4_full_ready", cmd_ready, 0);
    push(10'd99, 10'd0, 4'd0, 3'd0);
    check_eq("t4_over_cnt", fifo_count, 16);
    do_reset();

    // Continuous pushing across exactly one pop
    push(10'd100, 10'd0, 4'd0, 3'd0);
    push(10'd101, 10'd0, 4'd0, 3'd0);
    push(10'd102, 10'd0, 4'd0, 3'd0);
    pulse_commit();
    repeat (3) tick();
    pulse_frame();
    wait_draw("t4_draw_seen");
    check_eq("t4_after_pop", fifo_count, 2);
    cmd_valid = 1'b1;
    n = 0;
    seen_low = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      n++;
      if (!draw_start) seen_low = 1'b1;
      else if (seen_low) break;
    end
    cmd_valid = 1'b0;
    check_eq("t4_pushpop", fifo_count, 2 + n - 1);
    do_reset();

    // Accelerator never answers
    stuck = 1'b1;
    snap();
    for (int i = 0; i < 4; i++) push(10'(200 + i), 10'd0, 4'd0, 3'd0);
    pulse_commit();
    repeat (3) tick();
    pulse_frame();
    wait_bd(b_bd + 1, "t5_bd_wait");
    check_eq("t5_terr", timeout_err, 1);
    check_eq("t5_fifo", fifo_count, 0);
    check_eq("t5_bd_once", bd_cnt - b_bd, 1);
    check_eq("t5_clr_cycles", clr_high - b_high, TIMEOUT - 1);
    check_eq("t5_no_draw", drw_rise - b_drw, 0);
    check_eq("t5_clr_low", clear_start, 0);
    repeat (5) tick();
    check_eq("t5_terr_sticky", timeout_err, 1);
    stuck = 1'b0;
    do_reset();
    check_eq("t5_terr_rst", timeout_err, 0);

    // Empty batch: clear only
    snap();
    pulse_commit();
    repeat (3) tick();
    pulse_frame();
    wait_bd(b_bd + 1, "t6_bd_wait");
    check_eq("t6_clears", clr_rise - b_clr, 1);
    check_eq("t6_no_draw", drw_rise - b_drw, 0);

    // Commit while busy is serviced on the following frame
    snap();
    push(10'd77, 10'd7, 4'd7, 3'd7);
    pulse_commit();
    repeat (3) tick();
    pulse_frame();
    wait_draw("t6_draw_seen");
    push(10'd88, 10'd8, 4'd8, 3'd0);
    pulse_commit();
    wait_bd(b_bd + 1, "t6_bd1_wait");
    repeat (10) tick();
    check_eq("t6_waiting", busy, 1);
    check_eq("t6_clr_held", clr_rise - b_clr, 1);
    check_eq("t6_drw_held", drw_rise - b_drw, 1);
    pulse_frame();
    wait_bd(b_bd + 2, "t6_bd2_wait");
    check_eq("t6_draws", drw_rise - b_drw, 2);
    check_eq("t6_clears2", clr_rise - b_clr, 2);
    check_eq("t6_x0", xlog[b_x], 77);
    check_eq("t6_x1", xlog[b_x + 1], 88);
    check_eq("t6_fifo", fifo_count, 0);
    check_eq("no_overlap", overlap, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
